// File: rtl/obc_dft_pkg.sv
// Shared definitions for the OBC 16-point DFT datapath.
// Holds the FSM states and the common sample-to-slice bit mapping.
package obc_dft_pkg;

    localparam int N_POINTS = 16;
    localparam int ROM_W    = 32;
    localparam int MAX_DW   = 32;
    localparam int VEC_W    = N_POINTS * MAX_DW;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Bit j of every sample k, packed so that bit k of the result feeds x0k.
    function automatic logic [N_POINTS-1:0] slice_of(
        input logic [VEC_W-1:0] vec,
        input int               dw,
        input int               j
    );
        logic [N_POINTS-1:0] s;
        logic [VEC_W-1:0]    t;
        s = '0;
        for (int k = 0; k < N_POINTS; k++) begin
            t    = vec >> (k * dw + j);
            s[k] = t[0];
        end
        return s;
    endfunction

endpackage

// File: rtl/obc_slice_shifter.sv
// Sixteen parallel right-shift registers presenting one bit column.
// The LSB column of the registers is the current ROM slice.
module obc_slice_shifter
    import obc_dft_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   shift_i,
    input  logic [N_POINTS*DW-1:0] data_i,
    output logic [N_POINTS-1:0]    col_o
);

    logic [N_POINTS*DW-1:0] sh_q;
    logic [N_POINTS*DW-1:0] sh_d;

    // Load a fresh vector or shift every sample one bit toward the LSB.
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i;
        end else if (shift_i) begin
            for (int k = 0; k < N_POINTS; k++) begin
                sh_d[k*DW +: DW] = sh_q[k*DW +: DW] >> 1;
            end
        end
    end

    // Shift register state; zeros shift in, so the column clears itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign col_o = slice_of(VEC_W'(sh_q), DW, 0);

endmodule

// File: rtl/obc_da_slice_sequencer.sv
// Bit-serial driver and shift-accumulator around one OBC DA ROM.
// Feeds slices LSB first and sums the returned words into one DFT term.
module obc_da_slice_sequencer
    import obc_dft_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_POINTS*DW-1:0] samples,
    output logic [N_POINTS-1:0]    slice,
    output logic                   m,
    input  logic [ROM_W-1:0]       romout,
    output logic [ACC_W-1:0]       result,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int             CW   = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DW - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              ov_q, ov_d;
    logic              m_q, m_d;
    logic              rdy_q, rdy_d;
    logic              load;
    logic              shift;
    logic [ACC_W-1:0]  rom_ext;
    logic [ACC_W-1:0]  term;

    assign rom_ext = ACC_W'($signed(romout));
    assign term    = rom_ext << cnt_q;

    obc_slice_shifter #(
        .DW(DW)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .shift_i(shift),
        .data_i (samples),
        .col_o  (slice)
    );

    // Next-state, accumulate and handshake decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        ov_d     = ov_q;
        m_d      = m_q;
        load     = 1'b0;
        shift    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    m_d     = (DW == 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + term;
                shift = 1'b1;
                if (cnt_q == LAST) begin
                    result_d = acc_d;
                    ov_d     = 1'b1;
                    m_d      = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    m_d   = (cnt_d == LAST);
                end
            end
            DONE: begin
                if (ov_q && out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d = (state_d == IDLE);
    end

    // State and datapath registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ov_q     <= 1'b0;
            m_q      <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ov_q     <= ov_d;
            m_q      <= m_d;
            rdy_q    <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign m         = m_q;
    assign result    = result_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_obc_da_slice_sequencer.sv
// Self-checking bench for obc_da_slice_sequencer with a popcount ROM.
// Expected results are the signed sum of the 16 samples.
module tb_obc_da_slice_sequencer;

    localparam int DW    = 8;
    localparam int ACC_W = 32;
    localparam int NP    = 16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [NP*DW-1:0]  samples;
    logic [NP-1:0]     slice;
    logic              m;
    logic [31:0]       romout;
    logic [ACC_W-1:0]  result;
    logic              out_valid;
    logic              out_ready;

    int checks = 0;
    int errors = 0;

    obc_da_slice_sequencer #(
        .DW   (DW),
        .ACC_W(ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .samples  (samples),
        .slice    (slice),
        .m        (m),
        .romout   (romout),
        .result   (result),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM stand-in: popcount of the slice, negated on the MSB slice.
    always_comb begin
        int pc;
        pc     = $countones(slice);
        romout = m ? 32'(-pc) : 32'(pc);
    end

    function automatic logic [31:0] ref_sum(input logic [NP*DW-1:0] v);
        int s;
        logic signed [DW-1:0] b;
        s = 0;
        for (int k = 0; k < NP; k++) begin
            b = v[k*DW +: DW];
            s += int'(b);
        end
        return 32'(s);
    endfunction

    function automatic logic [NP-1:0] ref_slice(input logic [NP*DW-1:0] v, input int j);
        logic [NP-1:0] e;
        for (int k = 0; k < NP; k++) e[k] = v[k*DW + j];
        return e;
    endfunction

    function automatic logic [NP*DW-1:0] rand_vec();
        logic [NP*DW-1:0] v;
        for (int k = 0; k < NP; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic logic [NP*DW-1:0] fill(input logic [DW-1:0] b);
        logic [NP*DW-1:0] v;
        for (int k = 0; k < NP; k++) v[k*DW +: DW] = b;
        return v;
    endfunction

    // One full transaction: capture, per-slice checks, result, optional stall.
    task automatic do_txn(input logic [NP*DW-1:0] v, input int stall, input string nm);
        logic [31:0] exp_r;
        int n;
        exp_r = ref_sum(v);
        out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: in_ready=%b required 1", nm, in_ready);
        end
        samples  = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < DW; j++) begin
            checks++;
            if (slice !== ref_slice(v, j) || m !== (j == DW-1) ||
                out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s slice%0d: slice=%h m=%b ov=%b rdy=%b required slice=%h m=%b ov=0 rdy=0",
                         nm, j, slice, m, out_valid, in_ready, ref_slice(v, j), (j == DW-1));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1 || result !== exp_r || slice !== '0 ||
            m !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s result: ov=%b result=%h slice=%h m=%b rdy=%b required ov=1 result=%h slice=0 m=0 rdy=0",
                     nm, out_valid, result, slice, m, in_ready, exp_r);
        end
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            samples  = rand_vec();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== exp_r || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s stall%0d: ov=%b result=%h rdy=%b required ov=1 result=%h rdy=0",
                         nm, s, out_valid, result, in_ready, exp_r);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: ov=%b rdy=%b required ov=0 rdy=1", nm, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        samples   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (slice !== '0 || m !== 1'b0 || result !== '0 ||
            out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: slice=%h m=%b result=%h ov=%b rdy=%b required all 0",
                     slice, m, result, out_valid, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [NP*DW-1:0] v;
        do_txn(fill(8'h00), 0, "zeros");
        v = '0;
        v[7:0] = 8'h05;
        do_txn(v, 0, "s0_05");
        v[7:0] = 8'hFF;
        do_txn(v, 0, "s0_ff");
        do_txn(fill(8'h80), 0, "all_80");
        do_txn(fill(8'h7F), 0, "all_7f");
    endtask

    task automatic test_stall();
        do_txn(rand_vec(), 5, "stall5");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            do_txn(rand_vec(), int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [NP*DW-1:0] v1;
        logic [NP*DW-1:0] v2;
        int k;
        int ovc;
        v1 = rand_vec();
        v2 = rand_vec();
        out_ready = 1'b1;
        samples   = v1;
        in_valid  = 1'b1;
        @(negedge clk);
        samples = v2;
        k   = 0;
        ovc = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
            if (out_valid === 1'b1) begin
                ovc++;
                checks++;
                if (result !== ref_sum(v1)) begin
                    errors++;
                    $display("FAIL b2b_first_result: result=%h required %h", result, ref_sum(v1));
                end
            end
        end
        checks++;
        if (k + 1 != DW + 2 || ovc != 1) begin
            errors++;
            $display("FAIL b2b_spacing: capture gap=%0d ov_cycles=%0d required gap=%0d ov_cycles=1",
                     k + 1, ovc, DW + 2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (out_valid !== 1'b1 || result !== ref_sum(v2)) begin
            errors++;
            $display("FAIL b2b_second_result: ov=%b result=%h required ov=1 result=%h",
                     out_valid, result, ref_sum(v2));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [NP*DW-1:0] v;
        out_ready = 1'b1;
        samples   = rand_vec();
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (slice !== '0 || m !== 1'b0 || out_valid !== 1'b0 ||
            result !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_run: slice=%h m=%b ov=%b result=%h rdy=%b required all 0",
                     slice, m, out_valid, result, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: in_ready=%b required 1", in_ready);
        end
        v = '0;
        v[3*DW +: DW] = 8'h0A;
        do_txn(v, 0, "after_rst");
        checks++;
        if (result !== 32'd10) begin
            errors++;
            $display("FAIL after_rst_value: result=%h required %h", result, 32'd10);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/obc_da_slice_sequencer.md
# obc_da_slice_sequencer

Bit-serial front/back end for the OBC distributed-arithmetic ROM stage of the 16-point DFT. It captures 16 parallel signed samples and presents them to the combinational DA ROM one bit-slice per cycle, LSB first, asserting the sign flag `m` on the MSB slice. It shift-accumulates each returned 32-bit ROM word into one DFT output term. One instance drives one ROM; the DFT top instantiates one pair per output bin.

## Interface
- `DW`, 8: sample width, two's complement; equals the number of slices per transaction.
- `ACC_W`, 32: accumulator/result width; must be ≥ ROM word width (32).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample vector valid.
- `in_ready`  out  1  block can accept a vector; reset 0, then 1 in IDLE.
- `samples`  in  16*DW  sample k at bits `[k*DW +: DW]`.
- `slice`  out  16  to ROM x00..x015; `slice[k]` = bit j of sample k; reset 0.
- `m`  out  1  to ROM; 1 only while the MSB slice (j = DW-1) is driven; reset 0.
- `romout`  in  32  combinational ROM result for the current `slice`/`m`, two's complement.
- `result`  out  ACC_W  accumulated DFT term; reset 0.
- `out_valid`  out  1  `result` valid; reset 0.
- `out_ready`  in  1  downstream accepts `result`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE with accumulator, bit counter, `slice`, `m`, `result` and `out_valid` cleared.
- IDLE: `in_ready`=1. On `in_valid` the block captures `samples` into a shift register and clears the accumulator. It loads `slice` with bit 0 of every sample and sets `m`=(DW==1). It sets counter j=0 and moves to RUN.
- RUN: on each edge the accumulator is updated as acc ← acc + (sign_extend(romout) << j), computed modulo 2^ACC_W. The counter increments, and `slice`/`m` advance to bit j+1.
- On the edge that consumes slice j=DW-1: `result` ← final accumulator, `out_valid`←1, `slice`←0, `m`←0, and the FSM goes to DONE.
- DONE: `result` and `out_valid` are held stable until `out_valid && out_ready`. On that edge `out_valid` drops and the FSM goes to IDLE.
- No overlap between transactions: `in_ready`=0 in RUN and DONE. `in_valid` outside IDLE is ignored.
- Negative weighting of the MSB slice is done by the ROM via `m`. This block never negates.
- An all-zero slice yields `romout`=0 from the ROM. No special case exists in this block.
- Counter width is clog2(DW). The counter never wraps inside a transaction.

## Timing
- Capture edge = edge 0. Slice j is driven during cycle j+1, i.e. between edge j and edge j+1.
- `romout` is sampled on the edge that ends that cycle.
- `out_valid` rises on edge DW. Minimum throughput is one vector per DW+2 cycles with `out_ready` held high.
- With `out_ready` held high, `out_valid` is high for exactly one cycle.
- `rst` asserted at any time, including mid-RUN or in DONE, forces all outputs to their reset values immediately and aborts the transaction. After `rst` falls, the first rising edge brings the block to IDLE with `in_ready`=1.
- `in_valid` and `out_ready` are sampled only on the clock edge. Combinational glitches on them have no effect.

## Structure
- Shared package `obc_dft_pkg`:
  - `N_POINTS`=16 and `ROM_W`=32.
  - The FSM state enum (IDLE/RUN/DONE).
  - Sample-vector slicing helper, so the sibling ROM modules use the same bit-to-x0k mapping.
- One sub-module: `obc_slice_shifter`. It holds the 16 parallel DW-bit right-shift registers, loads on capture and shifts on advance. Its output is the LSB column, which becomes `slice`.
- Accumulator, counter and FSM live in the top module.

## Test plan
Bench ROM model: `romout` = popcount(`slice`), negated when `m`=1. With this model `result` equals the signed sum of the 16 samples. DW=8, ACC_W=32.
- All samples 8'h00 → `slice`=0 for all 8 cycles; `result`=0; `out_valid` on edge 8.
- Sample0=8'h05, others 0 → `slice` sequence 1,0,1,0,0,0,0,0 with `m`=1 only in cycle 8; `result`=32'd5.
- Sample0=8'hFF, others 0 → `result`=32'hFFFF_FFFF. All samples 8'h80 → `result`=32'hFFFF_F800.
- All samples 8'h7F → `result`=32'd2032. Back-to-back vectors with `out_ready`=1 → second `in_ready` rises exactly DW+2 cycles after the first capture.
- `out_ready` held low 5 cycles in DONE → `result` stable, `in_ready`=0, `in_valid` ignored. `out_ready`=1 → one handshake, then return to IDLE.
- `rst` pulsed during cycle 4 of RUN → `slice`, `m`, `out_valid`, `result` are 0 immediately and `in_ready`=1 after release. The next vector (sample3=8'h0A) yields `result`=32'd10.
